// File: rtl/peak_acq_pkg.sv
// Shared types and defaults for the peak-hold acquisition sequencer.
// Consumers: peak_cmp, peak_acq_sequencer.
package peak_acq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONV_HI = 3'd1,
    CONV_LO = 3'd2,
    CAPTURE = 3'd3,
    DISCH   = 3'd4,
    OUT     = 3'd5
  } state_t;

  localparam int         CNT_W         = 16;
  localparam int         HIGH_CYC_DEF  = 14;
  localparam int         LOW_CYC_DEF   = 264;
  localparam int         DISCH_CYC_DEF = 3;
  localparam logic [9:0] VREF_DEF      = 10'd392;

endpackage

// File: rtl/peak_cmp.sv
// Threshold comparator: over is set only when vpeak is strictly above VREF
// (unsigned). A code equal to VREF does not count as over.
module peak_cmp
  import peak_acq_pkg::*;
#(
  parameter logic [9:0] VREF = VREF_DEF
) (
  input  logic [9:0] vpeak,
  output logic       over
);

  assign over = (vpeak > VREF);

endmodule

// File: rtl/peak_acq_sequencer.sv
// Conversion strobe / capture / discharge sequencer for a peak-hold front end.
// Optional saturating over-threshold counter: define PEAK_ACQ_OVER_CNT_EN.
//
// Handshake: sample_valid is high only in OUT; sample_data/sample_over hold
// until sample_valid & sample_ready at a clk edge. sample_ready is ignored
// in every other state, so a pending sample is never dropped or overwritten.
module peak_acq_sequencer
  import peak_acq_pkg::*;
#(
  parameter int         HIGH_CYC  = HIGH_CYC_DEF,
  parameter int         LOW_CYC   = LOW_CYC_DEF,
  parameter int         DISCH_CYC = DISCH_CYC_DEF,
  parameter logic [9:0] VREF      = VREF_DEF
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        enable,
  input  logic [9:0]  vpeak,
  input  logic        sample_ready,
  output logic        conv,
  output logic        peak_reset,
  output logic [9:0]  sample_data,
  output logic        sample_over,
  output logic        sample_valid,
  output logic [15:0] over_cnt
);

  // Phase counters run 0..N-1, so the terminal compare is against N-1.
  localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LOW_CYC - 1);
  localparam logic [CNT_W-1:0] DI_LAST = CNT_W'(DISCH_CYC - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               over;

  peak_cmp #(.VREF(VREF)) u_cmp (
    .vpeak (vpeak),
    .over  (over)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = CONV_HI;
      end
      CONV_HI: begin
        if (cnt_q == HI_LAST) begin
          state_d = CONV_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONV_LO: begin
        if (cnt_q == LO_LAST) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        cnt_d   = '0;
        state_d = over ? DISCH : OUT;
      end
      DISCH: begin
        if (cnt_q == DI_LAST) begin
          state_d = OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        cnt_d = '0;
        // enable is only consulted here, so dropping it mid-frame finishes the frame
        if (sample_ready) state_d = enable ? CONV_HI : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    conv         = (state_q == CONV_HI);
    peak_reset   = (state_q == DISCH);
    sample_valid = (state_q == OUT);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sample_data <= '0;
      sample_over <= 1'b0;
    end else if (state_q == CAPTURE) begin
      sample_data <= vpeak;
      sample_over <= over;
    end
  end

`ifdef PEAK_ACQ_OVER_CNT_EN
  logic [15:0] over_cnt_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      over_cnt_q <= '0;
    end else if ((state_q == CAPTURE) && over && (over_cnt_q != 16'hFFFF)) begin
      over_cnt_q <= over_cnt_q + 16'd1;
    end
  end

  assign over_cnt = over_cnt_q;
`else
  assign over_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_peak_acq_sequencer.sv
// Directed bench for peak_acq_sequencer with HIGH_CYC=2, LOW_CYC=5, DISCH_CYC=3.
// Outputs are sampled 1 time unit after each rising clk edge.
module tb_peak_acq_sequencer;

  localparam int HC = 2;
  localparam int LC = 5;
  localparam int DC = 3;
`ifdef PEAK_ACQ_OVER_CNT_EN
  localparam bit OVC_EN = 1'b1;
`else
  localparam bit OVC_EN = 1'b0;
`endif

  logic        clk;
  logic        clear;
  logic        enable;
  logic [9:0]  vpeak;
  logic        sample_ready;
  logic        conv;
  logic        peak_reset;
  logic [9:0]  sample_data;
  logic        sample_over;
  logic        sample_valid;
  logic [15:0] over_cnt;

  int          n_tests;
  int          n_fail;
  int          n_over;
  logic [9:0]  exp_q[$];

  peak_acq_sequencer #(
    .HIGH_CYC  (HC),
    .LOW_CYC   (LC),
    .DISCH_CYC (DC),
    .VREF      (10'd392)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .enable       (enable),
    .vpeak        (vpeak),
    .sample_ready (sample_ready),
    .conv         (conv),
    .peak_reset   (peak_reset),
    .sample_data  (sample_data),
    .sample_over  (sample_over),
    .sample_valid (sample_valid),
    .over_cnt     (over_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_conv"}, 32'(conv), 32'd0);
    chk({tag, "_peak_reset"}, 32'(peak_reset), 32'd0);
    chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
  endtask

  // From IDLE: request a frame, conv must rise one cycle later.
  task automatic start_frame();
    enable = 1'b1;
    step();
    chk("start_conv", 32'(conv), 32'd1);
  endtask

  // Entered in CONV_HI cycle 0; returns in the first OUT cycle.
  task automatic frame(input logic [9:0] v, input logic exp_ov, input logic drop_en);
    vpeak = v;
    exp_q.push_back(v);
    for (int i = 1; i < HC; i++) begin
      step();
      chk("conv_hi", 32'(conv), 32'd1);
      chk("hi_peak_reset", 32'(peak_reset), 32'd0);
    end
    for (int i = 0; i < LC; i++) begin
      step();
      chk("conv_lo", 32'(conv), 32'd0);
      chk("lo_valid", 32'(sample_valid), 32'd0);
      if (drop_en && i == 1) enable = 1'b0;
    end
    step();
    chk_idle_outputs("capture");
    if (exp_ov) begin
      n_over++;
      for (int i = 0; i < DC; i++) begin
        step();
        chk("disch_peak_reset", 32'(peak_reset), 32'd1);
        chk("disch_valid", 32'(sample_valid), 32'd0);
      end
    end
    step();
    chk("out_valid", 32'(sample_valid), 32'd1);
    chk("out_peak_reset", 32'(peak_reset), 32'd0);
    chk("out_conv", 32'(conv), 32'd0);
    chk("out_data", 32'(sample_data), 32'(exp_q.pop_front()));
    chk("out_over", 32'(sample_over), 32'(exp_ov));
    chk("over_cnt", 32'(over_cnt), OVC_EN ? 32'(n_over) : 32'd0);
  endtask

  task automatic handshake(input logic en_next);
    sample_ready = 1'b1;
    enable       = en_next;
    step();
    sample_ready = 1'b0;
    chk("hs_valid", 32'(sample_valid), 32'd0);
    chk("hs_conv", 32'(conv), 32'(en_next));
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    n_over       = 0;
    clear        = 1'b0;
    enable       = 1'b0;
    vpeak        = 10'd0;
    sample_ready = 1'b0;

    // reset state
    #12;
    chk_idle_outputs("reset");
    chk("reset_data", 32'(sample_data), 32'd0);
    chk("reset_over", 32'(sample_over), 32'd0);
    chk("reset_over_cnt", 32'(over_cnt), 32'd0);
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle_outputs("post_reset_idle");
    end

    // below threshold, ready held high throughout
    sample_ready = 1'b1;
    start_frame();
    frame(10'd136, 1'b0, 1'b0);
    handshake(1'b1);

    // above threshold: discharge pulse before OUT
    frame(10'd908, 1'b1, 1'b0);
    handshake(1'b1);

    // threshold boundary
    frame(10'd392, 1'b0, 1'b0);
    handshake(1'b1);
    frame(10'd393, 1'b1, 1'b0);
    handshake(1'b1);

    // backpressure: OUT holds its sample while vpeak moves
    frame(10'd200, 1'b0, 1'b0);
    vpeak = 10'd700;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", 32'(sample_valid), 32'd1);
      chk("hold_data", 32'(sample_data), 32'd200);
      chk("hold_conv", 32'(conv), 32'd0);
    end
    handshake(1'b1);

    // enable dropped during CONV_LO: frame completes, then IDLE
    frame(10'd50, 1'b0, 1'b1);
    handshake(1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle_outputs("drop_idle");
    end

    // clear pulsed during DISCH
    vpeak = 10'd1000;
    start_frame();
    for (int i = 0; i < HC - 1 + LC + 1 + 1; i++) step();
    chk("pre_clear_peak_reset", 32'(peak_reset), 32'd1);
    step();
    clear = 1'b0;
    #1;
    chk_idle_outputs("clear");
    chk("clear_data", 32'(sample_data), 32'd0);
    chk("clear_over", 32'(sample_over), 32'd0);
    chk("clear_over_cnt", 32'(over_cnt), 32'd0);
    #1;
    clear  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle_outputs("after_clear_idle");
    end

    // frame after clear restarts cleanly, over_cnt from zero
    n_over = 0;
    start_frame();
    frame(10'd512, 1'b1, 1'b0);
    handshake(1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/peak_acq_sequencer.md
PEAK_ACQ_SEQUENCER -- requirements
Module: peak_acq_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; clock port clk, reset port clear.
REQ-002 Parameters SHALL be:
- HIGH_CYC, default 14: conv high width in clk cycles.
- LOW_CYC, default 264: conv low width in clk cycles.
- DISCH_CYC, default 3: peak_reset width in clk cycles.
- VREF, default 10'd392: comparator threshold.
REQ-003 Ports SHALL be:
- clk  in  1  system clock
- clear  in  1  async active-low reset
- enable  in  1  run request
- vpeak  in  10  peak-hold ADC code
- sample_ready  in  1  downstream accept
- conv  out  1  conversion strobe to peak-hold front end
- peak_reset  out  1  peak-hold discharge
- sample_data  out  10  captured vpeak
- sample_over  out  1  captured vpeak > VREF
- sample_valid  out  1  sample available
- over_cnt  out  16  over-threshold event count

Function
REQ-004 FSM SHALL have states IDLE, CONV_HI, CONV_LO, CAPTURE, DISCH and OUT.
REQ-005 In IDLE, enable=1 at a clk edge SHALL enter CONV_HI, so conv=1 on the next cycle (latency 1).
REQ-006 conv SHALL be 1 for exactly HIGH_CYC cycles in CONV_HI, then 0 for exactly LOW_CYC cycles in CONV_LO; conv SHALL be 0 in every other state.
REQ-007 CAPTURE SHALL last 1 cycle and register sample_data<=vpeak and sample_over<=(vpeak>VREF), an unsigned strict compare; vpeak==VREF SHALL NOT count as over.
REQ-008 From CAPTURE, an over sample SHALL go to DISCH and any other sample SHALL go to OUT.
REQ-009 In DISCH, peak_reset SHALL be 1 for exactly DISCH_CYC cycles, followed by OUT; peak_reset SHALL be 0 in all other states.
REQ-010 In OUT, sample_valid SHALL be 1; sample_data and sample_over SHALL stay stable until sample_valid&sample_ready at a clk edge.
REQ-011 On handshake, the FSM SHALL go to CONV_HI if enable=1 (back-to-back, conv rises next cycle) and to IDLE otherwise.
REQ-012 enable deasserted mid-frame SHALL NOT abort the frame; the frame SHALL complete through the OUT handshake, then go to IDLE.
REQ-013 sample_ready outside OUT SHALL be ignored; no sample SHALL be dropped or overwritten while sample_valid=1.
REQ-014 Phase counters SHALL be 16 bits; each parameter SHALL be between 1 and 65535, with no wrap within a phase.
REQ-015 A frame's first valid SHALL appear HIGH_CYC+LOW_CYC+1 cycles after conv rises if not over, and HIGH_CYC+LOW_CYC+1+DISCH_CYC cycles if over.

Reset
REQ-016 clear=0 SHALL immediately force IDLE, conv=0, peak_reset=0, sample_valid=0, sample_data=0, sample_over=0, over_cnt=0 and all counters to 0, in any state.
REQ-017 Reset release SHALL NOT start a frame until enable=1 is sampled in IDLE.

Configuration
REQ-018 With PEAK_ACQ_OVER_CNT_EN defined, over_cnt SHALL increment on each CAPTURE with sample_over=1 and saturate at 16'hFFFF.
REQ-019 Without PEAK_ACQ_OVER_CNT_EN, over_cnt SHALL be constant 0 and no counter logic SHALL be instantiated.

Structure
REQ-020 Package peak_acq_pkg SHALL hold the state enum, the default HIGH_CYC/LOW_CYC/DISCH_CYC values and VREF default 10'd392.
REQ-021 The threshold compare SHALL be the combinational sub-module peak_cmp (vpeak, VREF -> over).

Verification (bench params HIGH_CYC=2, LOW_CYC=5, DISCH_CYC=3)
REQ-022 enable=1, vpeak=136, ready=1 -> conv high 2 cycles, low 5; valid 1 cycle after CAPTURE; data=136, over=0; no peak_reset pulse.
REQ-023 vpeak=908 -> over=1; peak_reset high 3 cycles; valid 4 cycles after CAPTURE; over_cnt=1 (macro on), 0 (macro off).
REQ-024 vpeak=392 and vpeak=393 -> over=0 and over=1 respectively.
REQ-025 ready=0 for 10 cycles in OUT, vpeak changed -> valid held, data unchanged, conv stays 0; ready=1 with enable=1 -> conv=1 next cycle.
REQ-026 enable dropped during CONV_LO -> frame completes, handshake, then IDLE with conv=0.
REQ-027 clear=0 pulsed during DISCH -> peak_reset and all outputs 0 immediately; IDLE after release.
